// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: funct3 load/store codes, result-select
// encodings and the memory-stage state type.
package pipeline_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Stores only have signed-width encodings; loads add the unsigned pair.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/memory_cycle_lsu_align.sv
// Byte-lane alignment for the memory stage: store lane replication, byte
// enables, load lane selection with extension, and misalignment detection.
module lsu_align
    import pipeline_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_store_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] lane;

    assign lane = rdata_i >> {addr_lo_i, 3'b000};

    // Access size comes from funct3[1:0]; any unlisted encoding is rejected.
    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = wdata_i;
        misalign_o = ~f3_legal(funct3_i, is_store_i);
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
                if (addr_lo_i[0])
                    misalign_o = 1'b1;
            end
            2'b10: begin
                be_o = 4'b1111;
                if (addr_lo_i != 2'b00)
                    misalign_o = 1'b1;
            end
            default: misalign_o = 1'b1;
        endcase
    end

    // Load extension from the selected lane.
    always_comb begin
        rdata_o = lane;
        case (funct3_i)
            F3_B:    rdata_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    rdata_o = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   rdata_o = {24'h000000, lane[7:0]};
            F3_HU:   rdata_o = {16'h0000, lane[15:0]};
            default: rdata_o = lane;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: issues loads/stores on a valid/ready port, stalls upstream
// while an access is outstanding, aborts on timeout, registers M/W fields.
module memory_cycle
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] InstrM,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic        MisalignW,
    output logic        BusErrW
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic             we_q;
    logic [2:0]       f3_q;

    logic        in_wait, is_load, mem_op, is_store_sel, load_sel;
    logic [2:0]  f3_sel;
    logic [1:0]  lo_sel;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, rdata_ext;
    logic        mis_c, issue, mis_retire, to_hit, abort, req_raw, complete, stall_raw;

    assign in_wait      = (state_q == WAIT);
    assign is_load      = (ResultSrcM == RES_MEM);
    assign mem_op       = MemWriteM | is_load;
    assign f3_sel       = in_wait ? f3_q : InstrM[14:12];
    assign lo_sel       = in_wait ? addr_q[1:0] : ALUResultM[1:0];
    assign is_store_sel = in_wait ? we_q : MemWriteM;
    assign load_sel     = in_wait ? ~we_q : is_load;

    lsu_align u_align (
        .funct3_i   (f3_sel),
        .addr_lo_i  (lo_sel),
        .is_store_i (is_store_sel),
        .wdata_i    (WriteDataM),
        .rdata_i    (dmem_rdata),
        .be_o       (be_c),
        .wdata_o    (wdata_c),
        .rdata_o    (rdata_ext),
        .misalign_o (mis_c)
    );

    assign issue      = ~in_wait & mem_op & ~mis_c;
    assign mis_retire = ~in_wait & mem_op & mis_c;
    // Request stays up on the last count so a late ready still wins.
    assign to_hit     = in_wait & (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign abort      = to_hit & ~dmem_ready;
    assign req_raw    = issue | in_wait;
    assign complete   = req_raw & dmem_ready;
    assign stall_raw  = (issue & ~dmem_ready) | (in_wait & ~dmem_ready & ~to_hit);

    // Gating by rst drops the request the instant reset hits a pending access.
    assign dmem_req   = req_raw & ~rst;
    assign dmem_we    = dmem_req & is_store_sel;
    assign dmem_be    = dmem_req ? (in_wait ? be_q : be_c) : 4'b0000;
    assign dmem_addr  = in_wait ? {addr_q[31:2], 2'b00} : {ALUResultM[31:2], 2'b00};
    assign dmem_wdata = in_wait ? wdata_q : wdata_c;
    assign StallM     = stall_raw & ~rst;

    // IDLE/WAIT sequencing, wait counter and request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        addr_q  <= ALUResultM;
                        wdata_q <= wdata_c;
                        be_q    <= be_c;
                        we_q    <= MemWriteM;
                        f3_q    <= InstrM[14:12];
                        if (!dmem_ready) begin
                            state_q <= WAIT;
                            cnt_q   <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ready || to_hit)
                        state_q <= IDLE;
                    else
                        cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // M/W register: free-running; stalls and aborts retire as bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else begin
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            ResultSrcW <= ResultSrcM;
            ReadDataW  <= (complete & load_sel) ? rdata_ext : 32'h0;
            RegWriteW  <= RegWriteM & ~stall_raw & ~abort & ~mis_retire;
            MisalignW  <= mis_retire;
            BusErrW    <= abort;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle with a short timeout.
module tb_memory_cycle;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        StallM;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW, MisalignW, BusErrW;
    logic [1:0]  ResultSrcW;

    int n_cmp = 0;
    int n_mis = 0;

    memory_cycle #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .InstrM(InstrM), .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .StallM(StallM),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nop();
        ALUResultM = 32'h0; WriteDataM = 32'h0; PCPlus4M = 32'h0; InstrM = 32'h0;
        RdM = 5'd0; RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = RES_ALU;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic mop(input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input logic st, input logic [4:0] rd);
        ALUResultM = addr; WriteDataM = wd; PCPlus4M = 32'h0000_1000;
        InstrM = {17'h0, f3, 12'h003};
        MemWriteM = st; ResultSrcM = st ? RES_ALU : RES_MEM;
        RegWriteM = ~st; RdM = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        nop();
        #12;
        chk("rst_req",   32'(dmem_req),  32'h0);
        chk("rst_be",    32'(dmem_be),   32'h0);
        chk("rst_stall", 32'(StallM),    32'h0);
        chk("rst_regw",  32'(RegWriteW), 32'h0);
        chk("rst_rdw",   ReadDataW,      32'h0);
        chk("rst_buserr",32'(BusErrW),   32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // SW, ready in issue cycle
        mop(32'h100, 32'hDEADBEEF, F3_W, 1'b1, 5'd0);
        dmem_ready = 1'b1;
        #1;
        chk("sw_req",   32'(dmem_req), 32'h1);
        chk("sw_we",    32'(dmem_we),  32'h1);
        chk("sw_be",    32'(dmem_be),  32'hF);
        chk("sw_wdata", dmem_wdata,    32'hDEADBEEF);
        chk("sw_addr",  dmem_addr,     32'h100);
        chk("sw_stall", 32'(StallM),   32'h0);
        tick();
        chk("sw_regw",  32'(RegWriteW), 32'h0);
        chk("sw_mis",   32'(MisalignW), 32'h0);

        // LB with sign extension
        mop(32'h103, 32'h0, F3_B, 1'b0, 5'd5);
        dmem_ready = 1'b1; dmem_rdata = 32'h80123456;
        #1;
        chk("lb_we",   32'(dmem_we), 32'h0);
        chk("lb_be",   32'(dmem_be), 32'h8);
        chk("lb_addr", dmem_addr,    32'h100);
        tick();
        chk("lb_data", ReadDataW,        32'hFFFFFF80);
        chk("lb_src",  32'(ResultSrcW),  32'h1);
        chk("lb_regw", 32'(RegWriteW),   32'h1);
        chk("lb_rd",   32'(RdW),         32'h5);

        // LBU same address
        mop(32'h103, 32'h0, F3_BU, 1'b0, 5'd6);
        dmem_ready = 1'b1; dmem_rdata = 32'h80123456;
        tick();
        chk("lbu_data", ReadDataW, 32'h00000080);

        // LH upper half, sign-extended
        mop(32'h102, 32'h0, F3_H, 1'b0, 5'd6);
        dmem_ready = 1'b1; dmem_rdata = 32'h80123456;
        tick();
        chk("lh_data", ReadDataW, 32'hFFFF8012);

        // SH at upper half
        mop(32'h102, 32'h00001234, F3_H, 1'b1, 5'd0);
        dmem_ready = 1'b1;
        #1;
        chk("sh_be",    32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata,   32'h12341234);
        chk("sh_addr",  dmem_addr,    32'h100);
        tick();

        // SB lane replication
        mop(32'h101, 32'h000000A5, F3_B, 1'b1, 5'd0);
        dmem_ready = 1'b1;
        #1;
        chk("sb_be",    32'(dmem_be), 32'h2);
        chk("sb_wdata", dmem_wdata,   32'hA5A5A5A5);
        tick();

        // LW with ready three cycles after issue
        mop(32'h200, 32'h0, F3_W, 1'b0, 5'd9);
        dmem_ready = 1'b0;
        #1;
        chk("lwd_stall0", 32'(StallM), 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("lwd_bubble", 32'(RegWriteW), 32'h0);
            chk("lwd_stall",  32'(StallM),    32'h1);
            chk("lwd_addr",   dmem_addr,      32'h200);
        end
        tick();
        chk("lwd_bubble3", 32'(RegWriteW), 32'h0);
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("lwd_stall_rdy", 32'(StallM),   32'h0);
        chk("lwd_req_rdy",   32'(dmem_req), 32'h1);
        tick();
        chk("lwd_data", ReadDataW,      32'hCAFEF00D);
        chk("lwd_regw", 32'(RegWriteW), 32'h1);
        chk("lwd_rd",   32'(RdW),       32'h9);

        // Misaligned LW
        mop(32'h101, 32'h0, F3_W, 1'b0, 5'd3);
        dmem_ready = 1'b0;
        #1;
        chk("mis_req",   32'(dmem_req), 32'h0);
        chk("mis_stall", 32'(StallM),   32'h0);
        tick();
        chk("mis_flag", 32'(MisalignW), 32'h1);
        chk("mis_regw", 32'(RegWriteW), 32'h0);

        // Illegal funct3 on an aligned load
        mop(32'h100, 32'h0, 3'b011, 1'b0, 5'd3);
        #1;
        chk("ill_req", 32'(dmem_req), 32'h0);
        tick();
        chk("ill_flag", 32'(MisalignW), 32'h1);

        // Non-memory op; stray ready ignored
        nop();
        ALUResultM = 32'h55; PCPlus4M = 32'h1004; RdM = 5'd7;
        RegWriteM = 1'b1; ResultSrcM = RES_PC4; dmem_ready = 1'b1;
        #1;
        chk("alu_req", 32'(dmem_req), 32'h0);
        tick();
        chk("alu_regw", 32'(RegWriteW),  32'h1);
        chk("alu_pc4",  PCPlus4W,        32'h1004);
        chk("alu_res",  ALUResultW,      32'h55);
        chk("alu_src",  32'(ResultSrcW), 32'h2);
        chk("alu_mis",  32'(MisalignW),  32'h0);

        // Timeout: issue + 4 stalled wait cycles, abort on the fifth
        mop(32'h300, 32'h0, F3_W, 1'b0, 5'd10);
        dmem_ready = 1'b0;
        #1;
        chk("to_stall_issue", 32'(StallM), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_stall_wait", 32'(StallM),  32'h1);
            chk("to_no_buserr",  32'(BusErrW), 32'h0);
        end
        tick();
        chk("to_stall_last", 32'(StallM),   32'h0);
        chk("to_req_last",   32'(dmem_req), 32'h1);
        nop();
        tick();
        chk("to_buserr", 32'(BusErrW),   32'h1);
        chk("to_regw",   32'(RegWriteW), 32'h0);
        chk("to_idle_req", 32'(dmem_req), 32'h0);

        // Ready coinciding with the last count completes normally
        mop(32'h400, 32'h0, F3_W, 1'b0, 5'd12);
        dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        dmem_ready = 1'b1; dmem_rdata = 32'h11223344;
        #1;
        chk("tie_stall", 32'(StallM), 32'h0);
        tick();
        chk("tie_data",   ReadDataW,      32'h11223344);
        chk("tie_buserr", 32'(BusErrW),   32'h0);
        chk("tie_regw",   32'(RegWriteW), 32'h1);

        // Reset while waiting
        mop(32'h500, 32'h0, F3_W, 1'b0, 5'd11);
        dmem_ready = 1'b0;
        tick();
        tick();
        chk("rw_stall_pre", 32'(StallM), 32'h1);
        rst = 1'b1;
        #1;
        chk("rw_req",   32'(dmem_req), 32'h0);
        chk("rw_stall", 32'(StallM),   32'h0);
        chk("rw_alu",   ALUResultW,    32'h0);
        chk("rw_pc4",   PCPlus4W,      32'h0);
        chk("rw_rd",    32'(RdW),      32'h0);
        nop();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rw_after_req",  32'(dmem_req),  32'h0);
        chk("rw_after_regw", 32'(RegWriteW), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory stage of the five-stage RISC-V pipeline. It consumes the execute-to-memory pipeline outputs and performs loads and stores over a valid/ready data-memory port. It aligns store data and byte enables and sign- or zero-extends load data. It stalls the upstream stages while the memory is busy and registers the memory-to-writeback pipeline fields.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: wait cycles (after the issue cycle) before a pending access is aborted with a bus error; width of the counter is 8 bits.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ALUResultM  in  32  effective address / ALU result.
- WriteDataM  in  32  store data (rs2).
- PCPlus4M  in  32  return address.
- InstrM  in  32  instruction; funct3 = InstrM[14:12].
- RdM  in  5  destination register.
- RegWriteM, MemWriteM  in  1  control bits.
- ResultSrcM  in  2  result select (00 ALU, 01 memory, 10 PC+4); 01 marks a load.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  access complete this cycle.
- dmem_rdata  in  32  read word; valid when dmem_ready.
- StallM  out  1  freeze PC, F/D, D/E and E/M registers.
- ALUResultW, ReadDataW, PCPlus4W  out  32  writeback fields.
- RdW  out  5;  RegWriteW  out  1;  ResultSrcW  out  2.
- MisalignW  out  1  misaligned or illegal-funct3 access retired.
- BusErrW  out  1  timed-out access retired.

## Operation
- Memory op: MemWriteM=1 (store) or ResultSrcM=01 (load).
- Legal funct3 values:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
- Any other funct3 on a memory op is treated as misaligned.
- Misaligned cases:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠00.
- On a misaligned op:
  - No request is issued and there is no stall.
  - The op retires next cycle with MisalignW=1 and RegWriteW=0.
- Byte enables:
  - Byte access: be = 0001 << addr[1:0].
  - Half access: be = 0011 << addr[1:0].
  - Word access: be = 1111.
- Store data:
  - SB: {4{WriteDataM[7:0]}}.
  - SH: {2{WriteDataM[15:0]}}.
  - SW: WriteDataM unchanged.
- Load data:
  - Select the lane from dmem_rdata using the latched addr[1:0].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- State machine, IDLE / WAIT:
  - IDLE, legal memory op: dmem_req=1, driven combinationally from the M inputs. Request fields are latched.
  - IDLE, dmem_ready=1 in the same cycle: complete, no stall, stay in IDLE.
  - IDLE, dmem_ready=0: go to WAIT and clear the counter.
  - WAIT: dmem_req=1 with the latched address, data, be and we. StallM=1. The counter increments each cycle.
  - WAIT, dmem_ready: complete and return to IDLE.
  - WAIT, counter==TIMEOUT_CYCLES without ready: abort. Drop the request, retire with BusErrW=1 and RegWriteW=0, return to IDLE.
- StallM = (IDLE & legal op & ~dmem_ready) | (WAIT & ~dmem_ready & ~timeout).
- Upstream holds the M inputs stable while StallM=1.
- Non-memory ops pass through with one-cycle latency.

## Timing
- The M/W register updates every cycle; there is no enable.
- While stalled it captures a bubble: RegWriteW=0, MisalignW=0, BusErrW=0.
- On the completion cycle it captures the M fields, plus ReadDataW from the extended rdata.
- Load-to-W latency:
  - 1 cycle when ready arrives in the issue cycle.
  - N+1 cycles when ready arrives N cycles later.
- dmem_ready in IDLE without dmem_req is ignored.
- Reset values:
  - State IDLE, counter 0.
  - All W outputs 0.
  - dmem_req=0, dmem_we=0, dmem_be=0, StallM=0.
- Reset in WAIT aborts immediately: the request drops asynchronously and no W retirement occurs.
- Simultaneous ready and timeout at the last count: ready wins and the access completes normally.
- No back-to-back overlap: a new request is issued only from IDLE.

## Structure
- Shared package pipeline_pkg holds:
  - funct3 load/store constants.
  - ResultSrc encodings (RES_ALU=00, RES_MEM=01, RES_PC4=10).
  - State enum IDLE/WAIT.
- One combinational sub-module, lsu_align. It takes funct3, addr[1:0], store data and read data, and produces be, wdata, extended load data and misalign.
- FSM, counter, request latch and M/W register live in memory_cycle.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ready same cycle -> dmem_we=1, be=1111, wdata=0xDEADBEEF, StallM=0, next cycle RegWriteW=0.
- LB addr 0x103, rdata 0x80123456, ready same cycle -> ReadDataW=0xFFFFFF80, ResultSrcW=01, RegWriteW=1. LBU at the same address -> 0x00000080.
- SH addr 0x102, data 0x00001234 -> be=1100, wdata=0x12341234, dmem_addr=0x100.
- LW addr 0x200, ready 3 cycles after issue -> StallM high 3 cycles, dmem_addr held, W bubbles for 3 cycles, then ReadDataW=rdata.
- LW addr 0x101 -> dmem_req never asserted, StallM=0, MisalignW=1, RegWriteW=0.
- Ready never asserted with TIMEOUT_CYCLES=4 -> abort after 4 wait cycles, BusErrW=1. A second run asserting rst in WAIT drops dmem_req at once and clears StallM and all W outputs.
